// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder and the up/down counter it drives.
// Glyph constants are shared so both blocks show the same 'U'/'d' patterns.
package quad_pkg;

  localparam logic [6:0] SEG_UP  = 7'b0111110;
  localparam logic [6:0] SEG_DN  = 7'b1011110;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  typedef enum logic {INIT, RUN} state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_CCW, STEP_BAD} step_t;

  // Clockwise Gray order is 00->01->11->10->00; any other single-bit move is the reverse.
  function automatic step_t classify_step(input phase_t prev, input phase_t cur);
    step_t result;
    if ((prev ^ cur) == 2'b11) begin
      result = STEP_BAD;
    end else if (prev == cur) begin
      result = STEP_NONE;
    end else begin
      case ({prev, cur})
        {PH_00, PH_01},
        {PH_01, PH_11},
        {PH_11, PH_10},
        {PH_10, PH_00}: result = STEP_CW;
        default:        result = STEP_CCW;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/quad_debounce_ch.sv
// One encoder channel: two-flop synchroniser followed by a stability filter.
// filt only follows the synchronised level after DEB_CYCLES consecutive mismatching cycles.
module quad_debounce_ch #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // load bypasses the filter so power-up levels are adopted without a transition
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (load) begin
        filt <= s2;
        cnt  <= '0;
      end else if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Rotary encoder front end: conditions both channels, decodes Gray steps and emits
// single-cycle up/down/err pulses plus a registered direction glyph for the counter.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int DEB_CYCLES      = 4,
  parameter int STEPS_PER_PULSE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  output logic       up,
  output logic       down,
  output logic       err,
  output logic [6:0] seg
);

  localparam int INIT_W = $clog2(DEB_CYCLES + 3);
  localparam int ACC_W  = $clog2(STEPS_PER_PULSE + 1) + 2;

  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_PULSE);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-STEPS_PER_PULSE);

  state_t                   state;
  state_t                   state_next;
  logic [INIT_W-1:0]        init_cnt;
  logic [INIT_W-1:0]        init_cnt_next;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_sum;
  phase_t                   phase;
  phase_t                   prev;
  step_t                    step;
  logic                     load;
  logic                     filt_a;
  logic                     filt_b;
  logic                     up_next;
  logic                     down_next;
  logic                     err_next;
  logic [6:0]               seg_next;

  quad_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .raw  (a_in),
    .filt (filt_a)
  );

  quad_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .raw  (b_in),
    .filt (filt_b)
  );

  assign phase = {filt_a, filt_b};

  // INIT lasts long enough for the synchronisers and filters to settle on the pin levels
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    acc_next      = acc;
    acc_sum       = acc;
    step          = STEP_NONE;
    load          = 1'b0;
    up_next       = 1'b0;
    down_next     = 1'b0;
    err_next      = 1'b0;
    seg_next      = seg;

    unique case (state)
      INIT: begin
        load     = 1'b1;
        acc_next = '0;
        if (init_cnt == INIT_W'(DEB_CYCLES + 1)) begin
          state_next = RUN;
        end else begin
          init_cnt_next = init_cnt + INIT_W'(1);
        end
      end

      RUN: begin
        step = classify_step(prev, phase);
        unique case (step)
          STEP_CW:  acc_sum = acc + ACC_ONE;
          STEP_CCW: acc_sum = acc - ACC_ONE;
          default:  acc_sum = acc;
        endcase

        // a double-bit jump loses direction, so the partial count is discarded
        if (step == STEP_BAD) begin
          err_next = 1'b1;
          acc_next = '0;
          seg_next = SEG_OFF;
        end else if (acc_sum == ACC_MAX) begin
          up_next  = 1'b1;
          acc_next = '0;
          seg_next = SEG_UP;
        end else if (acc_sum == ACC_MIN) begin
          down_next = 1'b1;
          acc_next  = '0;
          seg_next  = SEG_DN;
        end else begin
          acc_next = acc_sum;
        end
      end

      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
      acc      <= '0;
      prev     <= PH_00;
      up       <= 1'b0;
      down     <= 1'b0;
      err      <= 1'b0;
      seg      <= SEG_OFF;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      acc      <= acc_next;
      prev     <= phase;
      up       <= up_next;
      down     <= down_next;
      err      <= err_next;
      seg      <= seg_next;
    end
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Input conditioner that drives the up/down command pair of the week-13 up/down counter.
- Takes the two raw channels of a mechanical quadrature (rotary) encoder from board pins, then synchronises, debounces and decodes them.
- Emits mutually exclusive single-cycle up/down step pulses, an error pulse, and a 7-segment direction glyph ('U'/'d').
- Sits between the encoder pins and the counter; its up/down outputs connect directly to the counter's up/down inputs.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles a synchronised channel must hold before its filtered value changes (legal range ≥1).
- STEPS_PER_PULSE, 1, valid quadrature transitions accumulated per output pulse (legal: 1, 2, 4).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (low at a rising clk edge resets the block)
- a_in  input  1  raw encoder channel A, asynchronous
- b_in  input  1  raw encoder channel B, asynchronous
- up  output  1  one-cycle pulse: one step clockwise
- down  output  1  one-cycle pulse: one step counter-clockwise
- err  output  1  one-cycle pulse: illegal phase jump (both channels changed in the same cycle)
- seg  output  7  direction glyph: 7'b0111110 'U', 7'b1011110 'd', 7'b0000000 blank

Behaviour:
- Reset (reset==0 at edge):
  - sync flops, filtered A/B, debounce counters, accumulator, up, down, err and seg all clear to 0.
  - FSM enters INIT.
  - Reset is honoured mid-operation on any cycle and overrides everything.
- Synchroniser: two flops per channel (s1, s2). Raw data sampled at edge k is visible on s2 after edge k+1.
- Debounce (per channel, independent):
  - cnt is clog2(DEB_CYCLES+1) bits wide.
  - While s2 != filt, cnt increments each edge.
  - On the edge where cnt==DEB_CYCLES-1 and the mismatch persists: filt <= s2, cnt <= 0.
  - Any edge with s2 == filt sets cnt <= 0, so glitches shorter than DEB_CYCLES cycles are rejected.
- FSM state INIT:
  - filt loads s2 directly every cycle; no decoding.
  - up, down and err are held at 0.
  - After DEB_CYCLES+2 cycles the FSM moves to RUN, so power-up level 11 does not produce err.
- FSM state RUN:
  - Each cycle, compare phase = {filtA, filtB} against prev (the registered phase from the previous cycle).
  - Clockwise Gray order is 00→01→11→10→00, giving acc +1. The reverse order gives acc −1.
  - No change: acc holds.
  - Both bits change: err pulse next cycle, acc <= 0, no up/down, prev resyncs to the new phase.
- Accumulator:
  - Signed, range −STEPS_PER_PULSE..+STEPS_PER_PULSE.
  - Reaching +STEPS_PER_PULSE: up=1 for exactly one cycle, acc <= 0.
  - Reaching −STEPS_PER_PULSE: down=1 for exactly one cycle, acc <= 0.
  - A reversal mid-accumulation simply counts back toward the other limit; a partial count never produces a pulse.
- Invariant: up & down is never 1. err is never coincident with up or down.
- Latency: up/down rises DEB_CYCLES+2 edges after the edge that first samples the new raw level (6 cycles at default), then lasts 1 cycle.
- seg:
  - Registered alongside the pulses.
  - Set to 'U' on an up pulse and 'd' on a down pulse.
  - Cleared to blank on an err pulse.
  - Otherwise holds its last value.
- Throughput: at most one pulse per DEB_CYCLES cycles per channel. Faster encoder motion is filtered, not queued.

Decomposition:
- Shared package (quad_pkg) holds:
  - seg glyph constants SEG_UP=7'b0111110, SEG_DN=7'b1011110, SEG_OFF=7'b0000000. The up/down counter also uses these.
  - FSM state encoding INIT, RUN.
  - Phase constants PH_00, PH_01, PH_11, PH_10.
- Sub-module quad_debounce_ch (parameter DEB_CYCLES; ports clk, reset, load, raw, filt): 2-flop synchroniser plus stability counter, instanced twice. The load input forces filt<=s2 during INIT.
- Top level holds the FSM, phase compare, accumulator and output registers.

Test Plan:
- Reset and INIT: hold reset low 3 cycles with a_in=b_in=1, release → up, down, err stay 0 throughout INIT; seg stays 0; after INIT, phase 11 is accepted silently.
- Clockwise sequence: defaults, step inputs 00→01→11→10→00 with 20-cycle dwell → four up pulses, each exactly 1 cycle, each 6 cycles after its raw change; seg=7'b0111110; down never 1.
- Counter-clockwise sequence with STEPS_PER_PULSE=4: drive 00→10→11→01→00 → exactly one down pulse, after the 4th transition; seg=7'b1011110.
- Bounce rejection: toggle a_in for 3 cycles then return, repeated 5 times → no filtered change, no pulses, no err.
- Illegal jump: drive 00→11 in one raw step on both channels → one err pulse, seg=0, acc cleared; then 11→10 → up pulse resumes normally.
- Reset mid-operation: with STEPS_PER_PULSE=2, make one CW transition, pull reset low for 1 cycle → all outputs 0 and acc 0; after INIT, one further transition gives no pulse; a second transition gives one up pulse.
